// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Result and overflow flag are registered and held until the next conversion completes.
module bin2bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DIGITS*4-1:0]   o_bcd,
  output logic                  o_ovf
);

  // One extra digit so every BIN_W-bit input converts exactly before saturation.
  localparam int SCR_W = (DIGITS + 1) * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [SCR_W-1:0]      scr_q, scr_d, scr_adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIGITS*4-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (scr_q[i*4 +: 4] >= 4'd5) begin
        scr_adj[i*4 +: 4] = scr_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          bin_d   = i_bin;
          scr_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        scr_d = {scr_adj[SCR_W-2:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (scr_q[SCR_W-1 -: 4] != 4'd0) begin
          bcd_d = {DIGITS{4'h9}};
          ovf_d = 1'b1;
        end else begin
          bcd_d = scr_q[DIGITS*4-1:0];
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_bcd  = bcd_q;
  assign o_ovf  = ovf_q;

endmodule
